// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed N-digit seven-segment scan controller
//
// Scans NUM_DIGITS hex digits onto a shared active-low segment bus. Values are
// captured into a shadow register, either on every valid (live mode) or at most
// once per capture window (rate-limited mode). Also provides leading-zero
// blanking and 1/8-step PWM dimming.
//
// Ports:
//   clk_sys        system clock
//   rst            synchronous active-high reset
//   in_vld         producer value valid
//   in_rdy         capture allowed this cycle (combinational)
//   in_data        hex nibbles, nibble i shows on digit i (digit 0 rightmost)
//   in_dots        decimal point i lit when 1
//   mode_live      0 = rate-limited capture, 1 = capture every valid
//   blank_lz       leading-zero blanking enable
//   dim            brightness, 7 = full, 0 = 1/8 duty
//   SEG_SELECT_OUT one-hot active-low digit enable (registered)
//   HEX_OUT        active-low segments, [6:0] = gfedcba, [7] = DP (registered)

module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 250000,
    parameter int UPDATE_TICKS = 200
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    input  logic [NUM_DIGITS-1:0]   in_dots,
    input  logic                    mode_live,
    input  logic                    blank_lz,
    input  logic [2:0]              dim,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
    output logic [7:0]              HEX_OUT
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int UW = $clog2(UPDATE_TICKS + 1);

    localparam logic [PW-1:0]         PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0]         DIG_MAX = DW'(NUM_DIGITS - 1);
    localparam logic [UW-1:0]         UPD_MAX = UW'(UPDATE_TICKS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

    logic [PW-1:0]           pre_cnt;
    logic [DW-1:0]           dig_idx;
    logic [UW-1:0]           upd_cnt;
    logic [2:0]              pwm_cnt;
    logic                    upd_rdy;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dots;

    logic                    tick;
    logic                    accept;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic                    cur_dot;
    logic                    lit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick   = (pre_cnt == PRE_MAX);
    assign in_rdy = mode_live ? 1'b1 : upd_rdy;
    assign accept = in_vld & in_rdy;

    // A digit is a leading zero when it and every more-significant digit carry
    // a zero nibble and no decimal point; walk from the top down.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (shadow_data[4*i +: 4] == 4'h0) && !shadow_dots[i];
            if (i != 0) begin
                blank[i] = zero_run;
            end
        end
        cur_nib = shadow_data[{dig_idx, 2'b00} +: 4];
        cur_dot = shadow_dots[dig_idx];
        lit     = !(blank_lz && blank[dig_idx]) && (pwm_cnt <= dim);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            pre_cnt        <= '0;
            dig_idx        <= '0;
            upd_cnt        <= '0;
            pwm_cnt        <= '0;
            upd_rdy        <= 1'b0;
            shadow_data    <= '0;
            shadow_dots    <= '0;
            SEG_SELECT_OUT <= '1;
            HEX_OUT        <= 8'hFF;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;

            if (tick) begin
                pre_cnt <= '0;
                dig_idx <= (dig_idx == DIG_MAX) ? '0 : dig_idx + 1'b1;
                if (upd_cnt == UPD_MAX) begin
                    upd_cnt <= '0;
                    upd_rdy <= 1'b1;
                end else begin
                    upd_cnt <= upd_cnt + 1'b1;
                end
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            // Placed after the window-wrap set so a coinciding accept clears it.
            if (accept) begin
                shadow_data <= in_data;
                shadow_dots <= in_dots;
                upd_rdy     <= 1'b0;
            end

            if (lit) begin
                SEG_SELECT_OUT <= ~(SEL_ONE << dig_idx);
                HEX_OUT        <= {~cur_dot, hex7(cur_nib)};
            end else begin
                SEG_SELECT_OUT <= '1;
                HEX_OUT        <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl

module tb_seg7_scan_ctrl;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [15:0] in_data = '0;
    logic [3:0]  in_dots = '0;
    logic        mode_live = 1'b1;
    logic        blank_lz = 1'b0;
    logic [2:0]  dim = 3'd7;
    logic [3:0]  seg;
    logic [7:0]  hex;

    int total = 0;
    int bad = 0;
    int k = 0;
    int lit_cnt = 0;

    logic [7:0] exp2 [4] = '{8'h8E, 8'h88, 8'h24, 8'hF9};

    always #5 clk_sys = ~clk_sys;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (4),
        .CLK_DIV     (8),
        .UPDATE_TICKS(3)
    ) dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .in_data       (in_data),
        .in_dots       (in_dots),
        .mode_live     (mode_live),
        .blank_lz      (blank_lz),
        .dim           (dim),
        .SEG_SELECT_OUT(seg),
        .HEX_OUT       (hex)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic [3:0] sel_of(input int d);
        logic [3:0] v;
        v = 4'b0001 << d;
        return ~v;
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk_sys);
        #1;
        rst = 1'b0;
        k = 0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst_sel", 16'(seg), 16'hF);
        check("rst_hex", 16'(hex), 16'hFF);
        check("rst_rdy_live", 16'(in_rdy), 16'h1);
        rst = 1'b0;
        k = 0;

        // 1. Reset scan: E,D,B,7,E each 8 cycles, all zeros shown
        for (int i = 1; i <= 33; i++) begin
            step();
            check("scan_sel", 16'(seg), 16'(sel_of(((i - 1) / 8) % 4)));
            check("scan_hex", 16'(hex), 16'hC0);
        end

        // 2. Live capture
        do_reset();
        in_vld  = 1'b1;
        in_data = 16'h12AF;
        in_dots = 4'b0100;
        step();
        in_vld = 1'b0;
        for (int d = 0; d < 4; d++) begin
            run_to(8 * d + 4);
            check("live_sel", 16'(seg), 16'(sel_of(d)));
            check("live_hex", 16'(hex), 16'(exp2[d]));
        end

        // 3. Rate limit with a value changing every cycle
        mode_live = 1'b0;
        in_dots   = 4'b0000;
        in_vld    = 1'b1;
        do_reset();
        for (int i = 0; i <= 50; i++) begin
            check("rl_rdy", 16'(in_rdy), (i == 24 || i == 48) ? 16'h1 : 16'h0);
            if (i == 34) begin
                check("rl_sel0", 16'(seg), 16'hE);
                check("rl_hex0", 16'(hex), 16'h80);
            end
            if (i == 42) begin
                check("rl_sel1", 16'(seg), 16'hD);
                check("rl_hex1", 16'(hex), 16'hF9);
            end
            in_data = 16'h1000 + 16'(i);
            step();
        end
        in_vld = 1'b0;

        // 4. Accept coinciding with the window wrap
        do_reset();
        run_to(47);
        check("col_rdy_pre", 16'(in_rdy), 16'h1);
        in_vld  = 1'b1;
        in_data = 16'h4321;
        step();
        in_vld = 1'b0;
        check("col_rdy_clr", 16'(in_rdy), 16'h0);
        run_to(60);
        check("col_sel3", 16'(seg), 16'h7);
        check("col_hex3", 16'(hex), 16'h99);
        run_to(66);
        check("col_sel0", 16'(seg), 16'hE);
        check("col_hex0", 16'(hex), 16'hF9);
        run_to(71);
        check("col_rdy_71", 16'(in_rdy), 16'h0);
        run_to(72);
        check("col_rdy_72", 16'(in_rdy), 16'h1);

        // 5. Leading-zero blanking
        mode_live = 1'b1;
        blank_lz  = 1'b1;
        do_reset();
        in_vld  = 1'b1;
        in_data = 16'h0050;
        in_dots = 4'b0000;
        step();
        in_vld = 1'b0;
        run_to(4);
        check("lz_sel0", 16'(seg), 16'hE);
        check("lz_hex0", 16'(hex), 16'hC0);
        run_to(12);
        check("lz_sel1", 16'(seg), 16'hD);
        check("lz_hex1", 16'(hex), 16'h92);
        run_to(20);
        check("lz_sel2", 16'(seg), 16'hF);
        check("lz_hex2", 16'(hex), 16'hFF);
        run_to(28);
        check("lz_sel3", 16'(seg), 16'hF);
        check("lz_hex3", 16'(hex), 16'hFF);

        do_reset();
        in_vld  = 1'b1;
        in_dots = 4'b1000;
        step();
        in_vld = 1'b0;
        run_to(20);
        check("lzd_sel2", 16'(seg), 16'hB);
        check("lzd_hex2", 16'(hex), 16'hC0);
        run_to(28);
        check("lzd_sel3", 16'(seg), 16'h7);
        check("lzd_hex3", 16'(hex), 16'h40);
        blank_lz = 1'b0;
        in_dots  = 4'b0000;

        // 6. Dimming, then reset mid-slot
        dim = 3'd1;
        do_reset();
        lit_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (hex != 8'hFF) lit_cnt++;
            check("dim_sel", 16'(seg), (i <= 2) ? 16'hE : 16'hF);
            check("dim_hex", 16'(hex), (i <= 2) ? 16'hC0 : 16'hFF);
        end
        check("dim_lit_cnt", 16'(lit_cnt), 16'd2);

        dim     = 3'd7;
        in_vld  = 1'b1;
        in_data = 16'hFFFF;
        step();
        in_vld = 1'b0;
        step();
        step();
        check("pre_rst_hex", 16'(hex), 16'h8E);
        rst = 1'b1;
        step();
        check("mid_rst_sel", 16'(seg), 16'hF);
        check("mid_rst_hex", 16'(hex), 16'hFF);
        rst = 1'b0;
        k = 0;
        step();
        check("post_rst_sel", 16'(seg), 16'hE);
        check("post_rst_hex", 16'(hex), 16'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
